sd_sector_sched: RTL and testbench

//  Sequences multi-sector SD card writes for one captured image frame. Sits between the
//  DDR3 readback FIFO and the single-block SD write engine (write_req/sec/write_o handshake).

---
 rtl/sd_sector_sched.sv | 161 ++++++++++++++++
 tb/tb_sd_sector_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_sched.sv
`timescale 1ns/1ps
// Frame-level SD write sequencer.
// For each sector it waits for one sector of data in the readback FIFO, then issues a
// single block write to the SD engine. It then waits for that write to complete and moves
// on to the next sector address. It ends by pulsing frame_done, or by raising a sticky
// timeout flag.
module sd_sector_sched #(
  parameter logic [15:0]     SEC_PER_FRAME = 16'd2048,
  parameter int unsigned     FIFO_CNT_W    = 11,
  parameter logic [10:0]     BYTES_PER_SEC = 11'd512,
  parameter logic [23:0]     TIMEOUT_CYC   = 24'd2000000
) (
  input  logic                  SD_clk,
  input  logic                  rst_n,
  input  logic                  init_done,
  input  logic                  start,
  input  logic [31:0]           frame_sec,
  input  logic [FIFO_CNT_W-1:0] fifo_rdcnt,
  input  logic                  write_o,
  output logic                  write_req,
  output logic [31:0]           sec,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_timeout,
  output logic [15:0]           sec_cnt
);

  localparam int unsigned SEC_W = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO_W = 24;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    REQ       = 3'd2,
    WAIT_DONE = 3'd3,
    NEXT      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [CNT_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               write_req_q, write_req_d;
  logic               frame_done_q, frame_done_d;
  logic               write_o_q;

  logic               fifo_ready_c;
  logic               done_rise_c;
  logic               tmo_hit_c;
  logic [CNT_W-1:0]   sec_cnt_inc_c;

  assign fifo_ready_c  = 32'(fifo_rdcnt) >= 32'(BYTES_PER_SEC);
  assign done_rise_c   = write_o & ~write_o_q;
  assign tmo_hit_c     = (tmo_q == TMO_W'(TIMEOUT_CYC - 24'd1));
  assign sec_cnt_inc_c = CNT_W'(sec_cnt_q + 16'd1);

  // State and registered outputs; write_o is delayed one cycle for completion-edge detection.
  always_ff @(posedge SD_clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sec_q        <= '0;
      sec_cnt_q    <= '0;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      write_req_q  <= 1'b0;
      frame_done_q <= 1'b0;
      write_o_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      sec_cnt_q    <= sec_cnt_d;
      tmo_q        <= tmo_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      write_req_q  <= write_req_d;
      frame_done_q <= frame_done_d;
      write_o_q    <= write_o;
    end
  end

  // Next-state logic; write_req/frame_done are computed one cycle early so the registered
  // versions line up with the REQ and NEXT states respectively.
  always_comb begin
    state_d      = state_q;
    sec_d        = sec_q;
    sec_cnt_d    = sec_cnt_q;
    tmo_d        = tmo_q;
    busy_d       = busy_q;
    err_d        = err_q;
    write_req_d  = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && init_done) begin
          sec_d     = frame_sec;
          sec_cnt_d = '0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (fifo_ready_c) begin
          write_req_d = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        tmo_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        tmo_d = TMO_W'(tmo_q + 24'd1);
        // A completion edge takes priority over a timeout in the same cycle.
        if (done_rise_c) begin
          sec_cnt_d    = sec_cnt_inc_c;
          frame_done_d = (sec_cnt_inc_c == SEC_PER_FRAME);
          state_d      = NEXT;
        end else if (tmo_hit_c) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      NEXT: begin
        if (sec_cnt_q == SEC_PER_FRAME) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          sec_d   = SEC_W'(sec_q + 32'd1);
          state_d = WAIT_DATA;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Losing card initialisation abandons the frame silently, keeping any timeout flag.
    if ((state_q != IDLE) && !init_done) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      write_req_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  assign write_req   = write_req_q;
  assign sec         = sec_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign err_timeout = err_q;
  assign sec_cnt     = sec_cnt_q;

endmodule

// File: tb/tb_sd_sector_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for sd_sector_sched: expected sector addresses are queued by the
// stimulus, and a negedge monitor pops them as write_req pulses appear.
module tb_sd_sector_sched;

  localparam logic [15:0] SPF     = 16'd4;
  localparam logic [23:0] TMO     = 24'd100;
  localparam int          ENG_LAT = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        start;
  logic [31:0] frame_sec;
  logic [10:0] fifo_rdcnt;
  logic        write_o;
  logic        write_req;
  logic [31:0] sec;
  logic        busy;
  logic        frame_done;
  logic        err_timeout;
  logic [15:0] sec_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_req    = 0;
  int          n_fd     = 0;
  logic [31:0] exp_q[$];
  int          req_cyc[$];
  logic        eng_hang = 1'b0;
  int          eng_cnt  = 0;

  always #5 clk = ~clk;

  sd_sector_sched #(
    .SEC_PER_FRAME (SPF),
    .FIFO_CNT_W    (11),
    .BYTES_PER_SEC (11'd512),
    .TIMEOUT_CYC   (TMO)
  ) dut (
    .SD_clk      (clk),
    .rst_n       (rst_n),
    .init_done   (init_done),
    .start       (start),
    .frame_sec   (frame_sec),
    .fifo_rdcnt  (fifo_rdcnt),
    .write_o     (write_o),
    .write_req   (write_req),
    .sec         (sec),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout),
    .sec_cnt     (sec_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter, read only at negedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: write_o drops on accepting a request and rises ENG_LAT cycles later.
  always @(posedge clk) begin
    if (!rst_n) begin
      write_o <= 1'b1;
      eng_cnt <= 0;
    end else begin
      if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) write_o <= 1'b1;
      end
      if (write_req) begin
        write_o <= 1'b0;
        eng_cnt <= eng_hang ? 0 : ENG_LAT;
      end
    end
  end

  // Monitor: every write_req must match the oldest expected sector address.
  always @(negedge clk) begin
    if (write_req) begin
      n_req++;
      req_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: sec 0x%0h issued, none expected (cycle %0d)", sec, cyc);
      end else begin
        check("req_sec", sec, exp_q.pop_front());
      end
    end
    if (frame_done) n_fd++;
  end

  task automatic pulse_start(input logic [31:0] fs, output int s);
    @(negedge clk);
    frame_sec = fs;
    start     = 1'b1;
    s         = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_reqs(input int target, input int limit, input string name);
    int k = 0;
    while (n_req < target && k < limit) begin
      @(posedge clk);
      k++;
    end
    check(name, 32'(n_req >= target), 32'd1);
  endtask

  task automatic wait_fd(input int target, input int limit, input string name);
    int k = 0;
    while (n_fd < target && k < limit) begin
      @(posedge clk);
      k++;
    end
    check(name, 32'(n_fd >= target), 32'd1);
  endtask

  task automatic push_frame(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(32'(first + 32'(i)));
  endtask

  initial begin
    int s;
    int c;
    int r;
    int nr0;
    int fd0;
    int k;

    rst_n      = 1'b0;
    init_done  = 1'b1;
    start      = 1'b0;
    frame_sec  = 32'h0;
    fifo_rdcnt = 11'd0;
    repeat (3) @(negedge clk);
    check("rst_write_req", 32'(write_req), 32'd0);
    check("rst_sec", sec, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_sec_cnt", 32'(sec_cnt), 32'd0);
    rst_n = 1'b1;

    // Start ignored while the card is not initialised.
    init_done  = 1'b0;
    fifo_rdcnt = 11'd600;
    pulse_start(32'h55, s);
    repeat (5) @(negedge clk);
    check("noinit_busy", 32'(busy), 32'd0);
    check("noinit_reqs", 32'(n_req), 32'd0);
    init_done = 1'b1;

    // 1: normal four-sector frame with latency checks.
    req_cyc.delete();
    fd0 = n_fd;
    push_frame(32'h100, 4);
    pulse_start(32'h100, s);
    wait_fd(fd0 + 1, 2000, "t1_frame_done");
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_sec_cnt", 32'(sec_cnt), 32'd4);
    check("t1_req_count", 32'(req_cyc.size()), 32'd4);
    if (req_cyc.size() == 4) begin
      check("t1_start_to_req", 32'(req_cyc[0] - s), 32'd2);
      check("t1_req_gap", 32'(req_cyc[1] - req_cyc[0]), 32'(ENG_LAT + 4));
      check("t1_req_gap_last", 32'(req_cyc[3] - req_cyc[2]), 32'(ENG_LAT + 4));
    end
    repeat (10) @(negedge clk);
    check("t1_fd_once", 32'(n_fd - fd0), 32'd1);

    // 2: FIFO one byte short for 1000 cycles.
    req_cyc.delete();
    nr0 = n_req;
    fd0 = n_fd;
    fifo_rdcnt = 11'd511;
    push_frame(32'h2000, 4);
    pulse_start(32'h2000, s);
    repeat (1000) @(negedge clk);
    check("t2_starved", 32'(n_req - nr0), 32'd0);
    fifo_rdcnt = 11'd512;
    c = cyc;
    wait_reqs(nr0 + 1, 20, "t2_req_seen");
    if (req_cyc.size() > 0) check("t2_fifo_to_req", 32'(req_cyc[0] - c), 32'd1);
    wait_fd(fd0 + 1, 2000, "t2_frame_done");
    fifo_rdcnt = 11'd600;

    // 3: engine never completes -> timeout, then a new start clears the flag.
    req_cyc.delete();
    nr0 = n_req;
    fd0 = n_fd;
    eng_hang = 1'b1;
    push_frame(32'h3000, 1);
    pulse_start(32'h3000, s);
    wait_reqs(nr0 + 1, 20, "t3_req_seen");
    r = (req_cyc.size() > 0) ? req_cyc[0] : cyc;
    @(negedge clk);
    k = 0;
    while (cyc < r + 100 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t3_err_before", 32'(err_timeout), 32'd0);
    check("t3_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    check("t3_err_set", 32'(err_timeout), 32'd1);
    check("t3_busy_clr", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("t3_err_sticky", 32'(err_timeout), 32'd1);
    check("t3_no_fd", 32'(n_fd - fd0), 32'd0);
    eng_hang = 1'b0;
    push_frame(32'h3100, 4);
    pulse_start(32'h3100, s);
    check("t3_err_cleared", 32'(err_timeout), 32'd0);
    wait_fd(fd0 + 1, 2000, "t3_frame_done");

    // 4: sector address wraps past 0xFFFFFFFF.
    fd0 = n_fd;
    push_frame(32'hFFFF_FFFF, 4);
    pulse_start(32'hFFFF_FFFF, s);
    wait_fd(fd0 + 1, 2000, "t4_frame_done");
    @(negedge clk);
    check("t4_sec_end", sec, 32'h2);
    repeat (10) @(negedge clk);
    check("t4_fd_once", 32'(n_fd - fd0), 32'd1);

    // 5a: init_done lost while sector 2 is outstanding.
    nr0 = n_req;
    fd0 = n_fd;
    push_frame(32'h5000, 2);
    pulse_start(32'h5000, s);
    wait_reqs(nr0 + 2, 500, "t5_two_reqs");
    @(negedge clk);
    init_done = 1'b0;
    @(negedge clk);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_err", 32'(err_timeout), 32'd0);
    repeat (80) @(negedge clk);
    check("t5_abort_no_fd", 32'(n_fd - fd0), 32'd0);
    check("t5_abort_reqs", 32'(n_req - nr0), 32'd2);
    init_done = 1'b1;

    // 5b: reset mid-frame returns every output to its reset value.
    nr0 = n_req;
    push_frame(32'h6000, 2);
    pulse_start(32'h6000, s);
    wait_reqs(nr0 + 2, 500, "t5_rst_two_reqs");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_write_req", 32'(write_req), 32'd0);
    check("t5_rst_sec", sec, 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_frame_done", 32'(frame_done), 32'd0);
    check("t5_rst_err", 32'(err_timeout), 32'd0);
    check("t5_rst_sec_cnt", 32'(sec_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("t5_rst_no_fd", 32'(n_fd - fd0), 32'd0);

    // 6: starts while busy and coincident with frame_done are dropped.
    nr0 = n_req;
    fd0 = n_fd;
    push_frame(32'h7000, 4);
    pulse_start(32'h7000, s);
    wait_reqs(nr0 + 1, 20, "t6_req_seen");
    @(negedge clk);
    frame_sec = 32'h9999;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!frame_done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("t6_fd_seen", 32'(frame_done), 32'd1);
    frame_sec = 32'hAAAA;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    check("t6_fd_once", 32'(n_fd - fd0), 32'd1);
    check("t6_req_count", 32'(n_req - nr0), 32'd4);
    check("t6_busy", 32'(busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
